// File: rtl/servo_pkg.sv
// Shared types and defaults for the multi-channel servo driver.
// Holds the 16-bit pulse type, the default timing constants and the
// fixed-point slope helper used by every channel's position map.
// Optional build macro: DEADBAND_EN (centre deadband in the map stage).
package servo_pkg;

  typedef logic [15:0] pw_t;

  localparam int unsigned DEF_N_CH        = 4;
  localparam int unsigned DEF_POS_W       = 10;
  localparam int unsigned DEF_CLK_HZ      = 25_000_000;
  localparam int unsigned DEF_FRAME_TICKS = 500_000;
  localparam int unsigned DEF_IN_MIN      = 228;
  localparam int unsigned DEF_IN_MAX      = 830;
  localparam int unsigned DEF_PW_MIN      = 12_500;
  localparam int unsigned DEF_PW_MAX      = 62_500;
  localparam int unsigned DEF_STEP        = 1_250;
  localparam int unsigned DEF_DEADBAND    = 8;

  // Fraction bits of the slope constant.
  localparam int unsigned K_FRAC = 16;

  // Slope rounded up so the map never lands below the exact value and the
  // top endpoint reaches PW_MAX (it is then saturated back to exactly PW_MAX).
  function automatic logic [63:0] calc_k(input int unsigned pw_min, input int unsigned pw_max,
                                         input int unsigned in_min, input int unsigned in_max);
    logic [63:0] num;
    logic [63:0] den;
    num = 64'(pw_max - pw_min) << K_FRAC;
    den = 64'(in_max - in_min);
    return (num + den - 64'd1) / den;
  endfunction

endpackage

// File: rtl/multi_servo_driver_if.sv
// Bus between the joystick/hold logic (master) and the servo driver (slave).
// Optional build macro of the driver: DEADBAND_EN.
//
// Handshake: pos_valid is a one-cycle strobe with no back-pressure; in the
// cycle it is high every pos_i lane and every hold bit is valid and sampled.
// hold[c] high in that cycle suppresses the update of channel c.
interface multi_servo_driver_if
  import servo_pkg::*;
#(
  parameter int unsigned N_CH  = DEF_N_CH,
  parameter int unsigned POS_W = DEF_POS_W
);
  logic [N_CH*POS_W-1:0] pos_i;
  logic                  pos_valid;
  logic [N_CH-1:0]       hold;
  logic [N_CH-1:0]       pwm_o;
  logic                  frame_tick;
  logic [N_CH-1:0]       moving;

  modport master (output pos_i, pos_valid, hold, input pwm_o, frame_tick, moving);
  modport slave  (input pos_i, pos_valid, hold, output pwm_o, frame_tick, moving);
endinterface

// File: rtl/servo_pwm_channel.sv
// One servo channel: clamp -> linear map (2-cycle pipeline) -> target with
// hold, once-per-frame slew of the live pulse, PWM compare and moving flag.
// Optional build macro: DEADBAND_EN (positions near centre map to PW_CTR).
module servo_pwm_channel
  import servo_pkg::*;
#(
  parameter int unsigned POS_W  = DEF_POS_W,
  parameter int unsigned IN_MIN = DEF_IN_MIN,
  parameter int unsigned IN_MAX = DEF_IN_MAX,
  parameter int unsigned PW_MIN = DEF_PW_MIN,
  parameter int unsigned PW_MAX = DEF_PW_MAX,
  parameter int unsigned STEP   = DEF_STEP,
  parameter int unsigned CNT_W  = 19
`ifdef DEADBAND_EN
  , parameter int unsigned DEADBAND = DEF_DEADBAND
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [POS_W-1:0] pos,
  input  logic             pos_valid,
  input  logic             hold,
  input  logic             frame_tick,
  input  logic [CNT_W-1:0] frame_cnt,
  output logic             pwm,
  output logic             moving
);

  localparam logic [POS_W-1:0] IN_MIN_P = POS_W'(IN_MIN);
  localparam logic [POS_W-1:0] IN_MAX_P = POS_W'(IN_MAX);
  localparam pw_t              PW_MAX_P = pw_t'(PW_MAX);
  localparam pw_t              PW_CTR   = pw_t'((PW_MIN + PW_MAX) / 2);
  localparam pw_t              STEP_P   = pw_t'(STEP);
  localparam logic [63:0]      K        = calc_k(PW_MIN, PW_MAX, IN_MIN, IN_MAX);

  logic [POS_W-1:0] pos_clamp;
  logic [POS_W-1:0] s1_pos;
  logic             s1_wr;
  logic [63:0]      lin_full;
  pw_t              pulse_lin;
  pw_t              pulse_map;
  logic             in_band;
  pw_t              target;
  pw_t              cur;

  // Clamp the raw position into the mapped input range.
  always_comb begin
    pos_clamp = pos;
    if (pos < IN_MIN_P)      pos_clamp = IN_MIN_P;
    else if (pos > IN_MAX_P) pos_clamp = IN_MAX_P;
  end

  // Stage 1: register the clamped position; hold in the strobe cycle wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_pos <= IN_MIN_P;
      s1_wr  <= 1'b0;
    end else begin
      s1_wr <= pos_valid & ~hold;
      if (pos_valid) s1_pos <= pos_clamp;
    end
  end

  // Stage 2 datapath: fixed-point linear map, saturated to PW_MAX.
  always_comb begin
    lin_full  = 64'(PW_MIN) + ((64'(s1_pos - IN_MIN_P) * K) >> K_FRAC);
    pulse_lin = (lin_full > 64'(PW_MAX)) ? PW_MAX_P : lin_full[15:0];
  end

`ifdef DEADBAND_EN
  localparam int unsigned IN_CTR = (IN_MIN + IN_MAX) / 2;
  // Centre deadband: |pos - IN_CTR| <= DEADBAND snaps to the centre pulse.
  always_comb begin
    in_band = ((32'(s1_pos) + DEADBAND) >= IN_CTR) && (32'(s1_pos) <= (IN_CTR + DEADBAND));
  end
`else
  // No deadband in this build: the linear map applies everywhere.
  always_comb begin
    in_band = 1'b0;
  end
`endif

  assign pulse_map = in_band ? PW_CTR : pulse_lin;

  // Stage 2 register: write the mapped pulse into the target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        target <= PW_CTR;
    else if (s1_wr) target <= pulse_map;
  end

  // Slew only at the frame boundary so a pulse in progress never changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur <= PW_CTR;
    end else if (frame_tick) begin
      if ({1'b0, target} > ({1'b0, cur} + {1'b0, STEP_P}))      cur <= cur + STEP_P;
      else if (({1'b0, target} + {1'b0, STEP_P}) < {1'b0, cur}) cur <= cur - STEP_P;
      else                                                      cur <= target;
    end
  end

  // Registered PWM compare and moving flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm    <= 1'b0;
      moving <= 1'b0;
    end else begin
      pwm    <= (32'(frame_cnt) < 32'(cur));
      moving <= (cur != target);
    end
  end

endmodule

// File: rtl/multi_servo_driver.sv
// N-channel joystick-to-servo driver: shared 50 Hz frame counter plus one
// servo_pwm_channel per channel.
// Optional build macro: DEADBAND_EN (centre deadband in each channel map).
module multi_servo_driver
  import servo_pkg::*;
#(
  parameter int unsigned N_CH        = DEF_N_CH,
  parameter int unsigned POS_W       = DEF_POS_W,
  parameter int unsigned CLK_HZ      = DEF_CLK_HZ,
  parameter int unsigned FRAME_TICKS = DEF_FRAME_TICKS,
  parameter int unsigned IN_MIN      = DEF_IN_MIN,
  parameter int unsigned IN_MAX      = DEF_IN_MAX,
  parameter int unsigned PW_MIN      = DEF_PW_MIN,
  parameter int unsigned PW_MAX      = DEF_PW_MAX,
  parameter int unsigned STEP        = DEF_STEP,
  parameter int unsigned DEADBAND    = DEF_DEADBAND
) (
  input logic                 clk,
  input logic                 rst,
  multi_servo_driver_if.slave bus
);

  localparam int unsigned      CNT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAME_TICKS - 1);

  // Reject parameter sets where the pulse cannot fit the frame or the type.
  if ((PW_MAX >= 65536) || (PW_MAX >= FRAME_TICKS) || (FRAME_TICKS > CLK_HZ) ||
      (IN_MAX <= IN_MIN) || (PW_MAX <= PW_MIN) || (DEADBAND >= (IN_MAX - IN_MIN) / 2)) begin : g_cfg_err
    $error("multi_servo_driver: inconsistent timing parameters");
  end

  logic [CNT_W-1:0] frame_cnt;
  logic             frame_tick;
  logic [N_CH-1:0]  pwm_v;
  logic [N_CH-1:0]  moving_v;

  // Free-running frame counter 0..FRAME_TICKS-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             frame_cnt <= '0;
    else if (frame_tick) frame_cnt <= '0;
    else                 frame_cnt <= frame_cnt + CNT_W'(1);
  end

  assign frame_tick = (frame_cnt == LAST);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    servo_pwm_channel #(
      .POS_W (POS_W),
      .IN_MIN(IN_MIN),
      .IN_MAX(IN_MAX),
      .PW_MIN(PW_MIN),
      .PW_MAX(PW_MAX),
      .STEP  (STEP),
      .CNT_W (CNT_W)
`ifdef DEADBAND_EN
      , .DEADBAND(DEADBAND)
`endif
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .pos       (bus.pos_i[c*POS_W +: POS_W]),
      .pos_valid (bus.pos_valid),
      .hold      (bus.hold[c]),
      .frame_tick(frame_tick),
      .frame_cnt (frame_cnt),
      .pwm       (pwm_v[c]),
      .moving    (moving_v[c])
    );
  end

  assign bus.pwm_o      = pwm_v;
  assign bus.moving     = moving_v;
  assign bus.frame_tick = frame_tick;

endmodule

// File: tb/tb_multi_servo_driver.sv
// Bench for multi_servo_driver with a shortened frame so full slews fit in a
// short run. Pulse widths are measured per frame and compared against a
// frame-level model of target/slew behaviour. Honours DEADBAND_EN.
`timescale 1ns/1ps
module tb_multi_servo_driver;
  import servo_pkg::*;

  localparam int N_CH   = 4;
  localparam int POS_W  = 10;
  localparam int FRAME  = 500;
  localparam int IN_MIN = 228;
  localparam int IN_MAX = 830;
  localparam int PW_MIN = 80;
  localparam int PW_MAX = 400;
  localparam int STEP   = 40;
  localparam int DB     = 8;
  localparam int PW_CTR = (PW_MIN + PW_MAX) / 2;
  localparam int IN_CTR = (IN_MIN + IN_MAX) / 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  multi_servo_driver_if #(.N_CH(N_CH), .POS_W(POS_W)) bus();

  multi_servo_driver #(
    .N_CH(N_CH), .POS_W(POS_W), .CLK_HZ(25_000_000), .FRAME_TICKS(FRAME),
    .IN_MIN(IN_MIN), .IN_MAX(IN_MAX), .PW_MIN(PW_MIN), .PW_MAX(PW_MAX),
    .STEP(STEP), .DEADBAND(DB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  int tgt_m[N_CH];
  int cur_m[N_CH];
  int tol_m[N_CH];
  int err_m[N_CH];
  int pos_req[N_CH];
  logic [15:0] exp_q[$];

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int clamp_pos(input int p);
    if (p < IN_MIN) return IN_MIN;
    if (p > IN_MAX) return IN_MAX;
    return p;
  endfunction

  // Exact truncated linear map (DUT may be at most one tick above it).
  function automatic int exp_pulse(input int p);
    int pc;
    pc = clamp_pos(p);
`ifdef DEADBAND_EN
    if (iabs(pc - IN_CTR) <= DB) return PW_CTR;
`endif
    return PW_MIN + (pc - IN_MIN) * (PW_MAX - PW_MIN) / (IN_MAX - IN_MIN);
  endfunction

  function automatic int exp_tol(input int p);
    int pc;
    pc = clamp_pos(p);
    if (pc == IN_MIN || pc == IN_MAX) return 0;
`ifdef DEADBAND_EN
    if (iabs(pc - IN_CTR) <= DB) return 0;
`endif
    return 1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      tgt_m[c] = PW_CTR; cur_m[c] = PW_CTR; tol_m[c] = 0; err_m[c] = 0; pos_req[c] = IN_CTR;
    end
  endtask

  // Frame boundary: pulse moves toward target by at most STEP.
  task automatic model_slew();
    for (int c = 0; c < N_CH; c++) begin
      if (cur_m[c] == tgt_m[c]) err_m[c] = tol_m[c];
      if (tgt_m[c] - cur_m[c] > STEP)       cur_m[c] = cur_m[c] + STEP;
      else if (cur_m[c] - tgt_m[c] > STEP)  cur_m[c] = cur_m[c] - STEP;
      else                                  cur_m[c] = tgt_m[c];
    end
  endtask

  // ---------------- monitor: high ticks per frame ----------------
  int meas[N_CH];
  int acc[N_CH];
  bit started = 1'b0;
  bit meas_ok = 1'b0;
  int frame_no = 0;

  always @(negedge clk) begin
    if (rst) begin
      started <= 1'b0;
      meas_ok <= 1'b0;
      for (int c = 0; c < N_CH; c++) acc[c] <= 0;
    end else if (bus.frame_tick) begin
      for (int c = 0; c < N_CH; c++) begin
        meas[c] <= acc[c] + int'(bus.pwm_o[c]);
        acc[c]  <= 0;
      end
      meas_ok  <= started;
      started  <= 1'b1;
      frame_no <= frame_no + 1;
    end else begin
      for (int c = 0; c < N_CH; c++) acc[c] <= acc[c] + int'(bus.pwm_o[c]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_strobe(input logic [N_CH-1:0] h);
    for (int c = 0; c < N_CH; c++) bus.pos_i[c*POS_W +: POS_W] = POS_W'(pos_req[c]);
    bus.hold      = h;
    bus.pos_valid = 1'b1;
    @(posedge clk); #1;
    bus.pos_valid = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (!h[c]) begin
        tgt_m[c] = exp_pulse(pos_req[c]);
        tol_m[c] = exp_tol(pos_req[c]);
        if (tol_m[c] > err_m[c]) err_m[c] = tol_m[c];
      end
    end
  endtask

  // Wait for the next frame end, compare widths, then advance the model.
  task automatic run_frame();
    int base;
    int n;
    base = frame_no;
    n = 0;
    while (frame_no == base && n < FRAME + 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (frame_no == base) begin
      total++; bad++;
      $display("FAIL frame_timeout: no frame_tick within %0d cycles", n);
    end else if (meas_ok) begin
      for (int c = 0; c < N_CH; c++) exp_q.push_back(16'(cur_m[c]));
      for (int c = 0; c < N_CH; c++) begin
        logic [15:0] e;
        e = exp_q.pop_front();
        total++;
        if (iabs(meas[c] - int'(e)) > err_m[c]) begin
          bad++;
          $display("FAIL width_ch%0d: got %0d ticks, expected %0d (+/-%0d)", c, meas[c], e, err_m[c]);
        end
      end
    end
    model_slew();
  endtask

  task automatic settle();
    int calm;
    calm = 0;
    for (int i = 0; i < 14 && calm < 2; i++) begin
      bit all_eq;
      run_frame();
      all_eq = 1'b1;
      for (int c = 0; c < N_CH; c++) if (cur_m[c] != tgt_m[c]) all_eq = 1'b0;
      calm = all_eq ? calm + 1 : 0;
    end
  endtask

  task automatic check_moving(input string name);
    logic [N_CH-1:0] mask;
    logic [N_CH-1:0] exp_mv;
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < N_CH; c++) begin
      mask[c]   = (err_m[c] == 0);
      exp_mv[c] = (cur_m[c] != tgt_m[c]);
    end
    total++;
    if ((bus.moving & mask) !== (exp_mv & mask)) begin
      bad++;
      $display("FAIL %s: moving=%b expected %b (mask %b)", name, bus.moving, exp_mv, mask);
    end
  endtask

  // Counts edges from reset release to the first frame_tick.
  task automatic check_first_tick(input string name);
    int n;
    n = 0;
    while (n < 2 * FRAME && bus.frame_tick !== 1'b1) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n != FRAME - 1) begin
      bad++;
      $display("FAIL %s: first frame_tick after %0d edges, expected %0d", name, n, FRAME - 1);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.pwm_o !== '0) begin bad++; $display("FAIL reset_pwm: got %b expected 0", bus.pwm_o); end
    total++;
    if (bus.frame_tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b expected 0", bus.frame_tick); end
    total++;
    if (bus.moving !== '0) begin bad++; $display("FAIL reset_moving: got %b expected 0", bus.moving); end
    rst = 1'b0;
    check_first_tick("reset_first_tick");
    run_frame();
    run_frame();
    check_moving("idle_moving");
  endtask

  task automatic test_slew_up();
    pos_req[0] = 830;
    do_strobe(4'b1110);
    check_moving("slew_start_moving");
    for (int i = 0; i < 5; i++) run_frame();
    settle();
    check_moving("slew_done_moving");
  endtask

  task automatic test_clamp();
    pos_req[0] = 100; pos_req[1] = 228; pos_req[2] = 529; pos_req[3] = 1000;
    do_strobe(4'b0000);
    settle();
    check_moving("clamp_moving");
  endtask

  task automatic test_hold();
    pos_req[1] = 830;
    do_strobe(4'b0010);
    check_moving("hold_moving");
    run_frame();
    run_frame();
    bus.hold = '0;
    run_frame();
    do_strobe(4'b0000);
    check_moving("hold_release_moving");
    settle();
  endtask

  task automatic test_deadband();
    pos_req[0] = 535; pos_req[1] = 537; pos_req[2] = 538; pos_req[3] = 540;
    do_strobe(4'b0000);
    settle();
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      for (int c = 0; c < N_CH; c++) pos_req[c] = int'($urandom_range(0, 1023));
      do_strobe(N_CH'($urandom_range(0, 15)));
      bus.hold = '0;
      settle();
    end
  endtask

  task automatic test_reset_mid_pulse();
    run_frame();
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (bus.pwm_o !== '1) begin bad++; $display("FAIL mid_pulse_high: got %b expected 1111", bus.pwm_o); end
    rst = 1'b1;
    #1;
    total++;
    if (bus.pwm_o !== '0) begin bad++; $display("FAIL mid_reset_pwm: got %b expected 0", bus.pwm_o); end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_first_tick("mid_reset_first_tick");
    run_frame();
    check_moving("mid_reset_moving");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.pos_i = '0;
    bus.pos_valid = 1'b0;
    bus.hold = '0;
    model_reset();
    #2 rst = 1'b1;
    test_reset();
    test_slew_up();
    test_clamp();
    test_hold();
    test_deadband();
    test_random();
    test_reset_mid_pulse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
